// File: rtl/clint_timer.sv
// clint_timer
//   Machine timer / counter block. Keeps a free-running 64-bit cycle counter,
//   a 64-bit microsecond mtime counter advanced by a prescaler, and a 64-bit
//   mtimecmp register. mtime and mtimecmp are reachable as 32-bit words over a
//   simple request/response port. mtip is the registered mtime >= mtimecmp.
//
// Ports
//   clk, rst_n       clock, asynchronous active-low reset
//   req_valid        register access request
//   req_ready        request can be accepted (high whenever out of reset)
//   req_addr         byte offset: 0x0/0x4 mtime lo/hi, 0x8/0xC mtimecmp lo/hi
//   req_wen          1 = write, 0 = read
//   req_wdata        write data
//   resp_valid       one-cycle completion pulse, cycle after acceptance
//   resp_rdata       read data (0 for writes and errors)
//   resp_error       offset not word aligned
//   reg_cycle        free-running cycle count
//   reg_time         current mtime
//   reg_mtimecmp     current mtimecmp
//   mtip             machine timer interrupt pending
module clint_timer #(
  parameter int unsigned FMAX_MHz       = 27,
  parameter logic [63:0] MTIMECMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_addr,
  input  logic        req_wen,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_error,
  output logic [63:0] reg_cycle,
  output logic [63:0] reg_time,
  output logic [63:0] reg_mtimecmp,
  output logic        mtip
);

  localparam logic [9:0] PRESCALE_MAX = 10'(FMAX_MHz - 1);

  logic [9:0]  prescaler;
  logic [9:0]  prescaler_next;
  logic        tick;
  logic        accept;
  logic        addr_error;
  logic        wr_time_lo;
  logic        wr_time_hi;
  logic        wr_cmp_lo;
  logic        wr_cmp_hi;
  logic [63:0] time_next;
  logic [63:0] cmp_next;
  logic [31:0] read_value;

  // Ready is simply "not in reset"; the block never back-pressures.
  assign req_ready = rst_n;

  // Request decode. Any misaligned offset is an error and changes no state.
  always_comb begin
    accept     = req_valid && req_ready;
    addr_error = (req_addr[1:0] != 2'b00);
    wr_time_lo = accept && req_wen && !addr_error && (req_addr[3:2] == 2'd0);
    wr_time_hi = accept && req_wen && !addr_error && (req_addr[3:2] == 2'd1);
    wr_cmp_lo  = accept && req_wen && !addr_error && (req_addr[3:2] == 2'd2);
    wr_cmp_hi  = accept && req_wen && !addr_error && (req_addr[3:2] == 2'd3);
  end

  // mtime next value. A half write wins over a tick on the same cycle and the
  // untouched half keeps its pre-tick value, so no carry leaks across. Any
  // mtime write restarts the prescaler so the next tick is a full period away.
  always_comb begin
    tick           = (prescaler == PRESCALE_MAX);
    prescaler_next = tick ? 10'd0 : prescaler + 10'd1;
    time_next      = reg_time + {63'd0, tick};
    if (wr_time_lo) begin
      time_next      = {reg_time[63:32], req_wdata};
      prescaler_next = 10'd0;
    end
    if (wr_time_hi) begin
      time_next      = {req_wdata, reg_time[31:0]};
      prescaler_next = 10'd0;
    end
  end

  // mtimecmp half writes leave the other half alone.
  always_comb begin
    cmp_next = reg_mtimecmp;
    if (wr_cmp_lo) cmp_next[31:0]  = req_wdata;
    if (wr_cmp_hi) cmp_next[63:32] = req_wdata;
  end

  // Read mux samples the registers as they stand before this edge's update.
  always_comb begin
    read_value = 32'd0;
    case (req_addr[3:2])
      2'd0:    read_value = reg_time[31:0];
      2'd1:    read_value = reg_time[63:32];
      2'd2:    read_value = reg_mtimecmp[31:0];
      default: read_value = reg_mtimecmp[63:32];
    endcase
  end

  // Counters and registers. mtip compares the registered values, so it
  // follows any tick or write one cycle after the new value is visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_cycle    <= 64'd0;
      reg_time     <= 64'd0;
      prescaler    <= 10'd0;
      reg_mtimecmp <= MTIMECMP_RESET;
      mtip         <= 1'b0;
    end else begin
      reg_cycle    <= reg_cycle + 64'd1;
      reg_time     <= time_next;
      prescaler    <= prescaler_next;
      reg_mtimecmp <= cmp_next;
      mtip         <= (reg_time >= reg_mtimecmp);
    end
  end

  // Response path: one pulse per accepted request; reset drops anything pending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid <= 1'b0;
      resp_rdata <= 32'd0;
      resp_error <= 1'b0;
    end else begin
      resp_valid <= accept;
      if (accept) begin
        resp_error <= addr_error;
        resp_rdata <= (req_wen || addr_error) ? 32'd0 : read_value;
      end
    end
  end

endmodule

// File: tb/tb_clint_timer.sv
// tb_clint_timer
//   Self-checking bench for clint_timer with FMAX_MHz = 4. A reference model
//   describes mtime as "base + elapsed cycles / FMAX" since the last mtime
//   write, and a compare process checks every DUT output against it on each
//   falling edge. Directed sequences add hand-computed literal checks.
module tb_clint_timer;

  localparam int unsigned FMAX = 4;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_addr;
  logic        req_wen;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_error;
  logic [63:0] reg_cycle;
  logic [63:0] reg_time;
  logic [63:0] reg_mtimecmp;
  logic        mtip;

  int tests_run;
  int tests_failed;

  clint_timer #(
    .FMAX_MHz(FMAX),
    .MTIMECMP_RESET(64'hFFFF_FFFF_FFFF_FFFF)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_addr(req_addr),
    .req_wen(req_wen),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid),
    .resp_rdata(resp_rdata),
    .resp_error(resp_error),
    .reg_cycle(reg_cycle),
    .reg_time(reg_time),
    .reg_mtimecmp(reg_mtimecmp),
    .mtip(mtip)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  logic [63:0] m_cycle;
  logic [63:0] m_base;
  logic [63:0] m_epoch;
  logic [63:0] m_cmp;
  logic        m_mtip;
  logic        m_rvalid;
  logic [31:0] m_rdata;
  logic        m_rerr;
  logic        model_live;

  initial model_live = 1'b0;

  function automatic logic [63:0] model_time(input logic [63:0] cyc);
    return m_base + (cyc - m_epoch) / 64'(FMAX);
  endfunction

  task automatic check_output(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // Model: mtime is the last written base plus whole prescaler periods since
  // that write; mtip is the comparison of what was visible before this edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cycle  = 64'd0;
      m_base   = 64'd0;
      m_epoch  = 64'd0;
      m_cmp    = 64'hFFFF_FFFF_FFFF_FFFF;
      m_mtip   = 1'b0;
      m_rvalid = 1'b0;
      m_rdata  = 32'd0;
      m_rerr   = 1'b0;
    end else begin
      logic [63:0] t_now;
      t_now    = model_time(m_cycle);
      m_mtip   = (t_now >= m_cmp);
      m_rvalid = req_valid;
      if (req_valid) begin
        m_rerr  = (req_addr[1:0] != 2'b00);
        m_rdata = 32'd0;
        if (!m_rerr && !req_wen) begin
          case (req_addr)
            4'h0:    m_rdata = t_now[31:0];
            4'h4:    m_rdata = t_now[63:32];
            4'h8:    m_rdata = m_cmp[31:0];
            default: m_rdata = m_cmp[63:32];
          endcase
        end
        if (!m_rerr && req_wen) begin
          case (req_addr)
            4'h0: begin m_base = {t_now[63:32], req_wdata}; m_epoch = m_cycle + 64'd1; end
            4'h4: begin m_base = {req_wdata, t_now[31:0]};  m_epoch = m_cycle + 64'd1; end
            4'h8:    m_cmp[31:0]  = req_wdata;
            default: m_cmp[63:32] = req_wdata;
          endcase
        end
      end
      m_cycle = m_cycle + 64'd1;
    end
    model_live = 1'b1;
  end

  // Compare process: every falling edge once the model has seen a clock.
  always @(negedge clk) begin
    if (model_live) begin
      check_output("cycle", reg_cycle, m_cycle);
      check_output("mtime", reg_time, model_time(m_cycle));
      check_output("mtimecmp", reg_mtimecmp, m_cmp);
      check_output("mtip", {63'd0, mtip}, {63'd0, m_mtip});
      check_output("resp_valid", {63'd0, resp_valid}, {63'd0, m_rvalid});
      check_output("req_ready", {63'd0, req_ready}, {63'd0, rst_n});
      if (m_rvalid) begin
        check_output("resp_rdata", {32'd0, resp_rdata}, {32'd0, m_rdata});
        check_output("resp_error", {63'd0, resp_error}, {63'd0, m_rerr});
      end
    end
  end

  // Inputs change 2 time units after the rising edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic apply_stimulus(input logic wen, input logic [3:0] addr,
                                input logic [31:0] wdata);
    req_valid = 1'b1;
    req_wen   = wen;
    req_addr  = addr;
    req_wdata = wdata;
    step(1);
    req_valid = 1'b0;
    req_wen   = 1'b0;
    req_addr  = 4'h0;
    req_wdata = 32'd0;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n        = 1'b0;
    req_valid    = 1'b0;
    req_wen      = 1'b0;
    req_addr     = 4'h0;
    req_wdata    = 32'd0;
    step(2);
    rst_n = 1'b1;

    // Reset values and free-running counting
    check_output("rst_cycle", reg_cycle, 64'd0);
    check_output("rst_cmp", reg_mtimecmp, 64'hFFFF_FFFF_FFFF_FFFF);
    step(4);
    check_output("cycle_4", reg_cycle, 64'd4);
    check_output("time_after_4", reg_time, 64'd1);
    step(4);
    check_output("time_after_8", reg_time, 64'd2);
    check_output("mtip_idle", {63'd0, mtip}, 64'd0);

    // mtimecmp = 10: mtip rises one cycle after mtime reaches 10
    apply_stimulus(1'b1, 4'h8, 32'd10);
    apply_stimulus(1'b1, 4'hC, 32'd0);
    check_output("cmp_10", reg_mtimecmp, 64'd10);
    for (int i = 0; i < 100 && reg_time != 64'd10; i++) step(1);
    check_output("time_reaches_10", reg_time, 64'd10);
    check_output("cycle_at_10", reg_cycle, 64'd40);
    check_output("mtip_before_rise", {63'd0, mtip}, 64'd0);
    step(1);
    check_output("mtip_rise", {63'd0, mtip}, 64'd1);
    apply_stimulus(1'b1, 4'h8, 32'd100);
    check_output("mtip_still_high", {63'd0, mtip}, 64'd1);
    step(1);
    check_output("mtip_fall", {63'd0, mtip}, 64'd0);

    // Carry from bit 31 into bit 32
    apply_stimulus(1'b1, 4'h0, 32'hFFFF_FFFF);
    apply_stimulus(1'b1, 4'h4, 32'd0);
    check_output("time_pre_carry", reg_time, 64'h0000_0000_FFFF_FFFF);
    step(4);
    check_output("time_carry", reg_time, 64'h0000_0001_0000_0000);
    apply_stimulus(1'b0, 4'h4, 32'd0);
    check_output("read_hi_valid", {63'd0, resp_valid}, 64'd1);
    check_output("read_hi", {32'd0, resp_rdata}, 64'd1);
    apply_stimulus(1'b0, 4'h0, 32'd0);
    check_output("read_lo", {32'd0, resp_rdata}, 64'd0);

    // Write mtime lo on the exact tick cycle
    step(1);
    check_output("tick_cycle", reg_cycle, 64'd52);
    apply_stimulus(1'b1, 4'h0, 32'd5);
    check_output("tick_write", reg_time, 64'h0000_0001_0000_0005);
    step(3);
    check_output("no_early_tick", reg_time, 64'h0000_0001_0000_0005);
    step(1);
    check_output("tick_after_fmax", reg_time, 64'h0000_0001_0000_0006);

    // Back-to-back accesses, last one misaligned
    req_valid = 1'b1; req_wen = 1'b0; req_addr = 4'h0; req_wdata = 32'd0;
    step(1);
    check_output("b2b0_valid", {63'd0, resp_valid}, 64'd1);
    check_output("b2b0_rdata", {32'd0, resp_rdata}, 64'd6);
    req_addr = 4'h8;
    step(1);
    check_output("b2b1_valid", {63'd0, resp_valid}, 64'd1);
    check_output("b2b1_rdata", {32'd0, resp_rdata}, 64'd100);
    req_wen = 1'b1; req_addr = 4'hC; req_wdata = 32'd2;
    step(1);
    check_output("b2b2_valid", {63'd0, resp_valid}, 64'd1);
    check_output("b2b2_rdata", {32'd0, resp_rdata}, 64'd0);
    req_wen = 1'b0; req_addr = 4'h3; req_wdata = 32'd0;
    step(1);
    check_output("b2b3_valid", {63'd0, resp_valid}, 64'd1);
    check_output("b2b3_error", {63'd0, resp_error}, 64'd1);
    check_output("b2b3_rdata", {32'd0, resp_rdata}, 64'd0);
    check_output("b2b_cmp", reg_mtimecmp, 64'h0000_0002_0000_0064);
    req_valid = 1'b0; req_addr = 4'h0;
    step(1);
    check_output("b2b_idle", {63'd0, resp_valid}, 64'd0);

    // Reset pulse with a request just accepted
    req_valid = 1'b1; req_wen = 1'b0; req_addr = 4'h8;
    step(1);
    rst_n = 1'b0;
    #1;
    check_output("mid_rst_valid", {63'd0, resp_valid}, 64'd0);
    check_output("mid_rst_ready", {63'd0, req_ready}, 64'd0);
    check_output("mid_rst_cycle", reg_cycle, 64'd0);
    check_output("mid_rst_time", reg_time, 64'd0);
    check_output("mid_rst_cmp", reg_mtimecmp, 64'hFFFF_FFFF_FFFF_FFFF);
    check_output("mid_rst_mtip", {63'd0, mtip}, 64'd0);
    step(1);
    rst_n     = 1'b1;
    req_valid = 1'b0;
    req_addr  = 4'h0;
    check_output("post_rst_valid", {63'd0, resp_valid}, 64'd0);
    step(4);
    check_output("post_rst_cycle", reg_cycle, 64'd4);
    check_output("post_rst_time", reg_time, 64'd1);
    step(2);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
